// File: rtl/branch_sequencer_if.sv
// Control-flow bundle between decode/ALU/instruction memory and the branch sequencer.
// The master modport is the environment side; the slave modport is the sequencer.
interface branch_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic             instr_valid;
  logic             instr_ready;
  logic [1:0]       br_class;
  logic [1:0]       ShortBrType;
  logic [15:0]      offset;
  logic [31:0]      target;
  logic             flag_valid;
  logic             zero;
  logic             MSB;
  logic             imem_req;
  logic             imem_ack;
  logic [31:0]      pc;
  logic             flush;
  logic             link_we;
  logic [31:0]      link_data;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output instr_valid, br_class, ShortBrType, offset, target,
    output flag_valid, zero, MSB, imem_ack,
    input  instr_ready, imem_req, pc, flush, link_we, link_data, taken_cnt
  );

  modport slave (
    input  instr_valid, br_class, ShortBrType, offset, target,
    input  flag_valid, zero, MSB, imem_ack,
    output instr_ready, imem_req, pc, flush, link_we, link_data, taken_cnt
  );
endinterface

// File: rtl/branch_sequencer.sv
// Program-counter sequencer: accepts decoded control-flow info, resolves short
// conditional branches against ALU flags, handles jumps/calls and drives fetch.
module branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic           clk,
  input logic           rst_n,
  branch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_FLAG, UPDATE, FETCH} state_t;

  state_t           state, state_next;
  logic [31:0]      pc, pc_next;
  logic [1:0]       cls, br_type;
  logic [15:0]      off;
  logic [29:0]      tgt_word;
  logic             flush, redirect, taken;
  logic [CNT_W-1:0] taken_cnt;
  logic [31:0]      branch_off;

  assign branch_off = {{14{off[15]}}, off, 2'b00};

  always_comb begin
    taken = 1'b0;
    case (br_type)
      2'b00: taken = ~bus.MSB;
      2'b01: taken = bus.MSB;
      2'b10: taken = bus.zero;
      2'b11: taken = ~bus.zero;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Flags only matter in WAIT_FLAG; every redirect marks the fetched path stale.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    redirect   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.instr_valid) begin
          case (bus.br_class)
            2'b00: begin
              state_next = FETCH;
              pc_next    = pc + 32'd4;
            end
            2'b01:   state_next = WAIT_FLAG;
            default: state_next = UPDATE;
          endcase
        end
      end
      WAIT_FLAG: begin
        if (bus.flag_valid) begin
          state_next = FETCH;
          if (taken) begin
            pc_next  = pc + 32'd4 + branch_off;
            redirect = 1'b1;
          end else begin
            pc_next  = pc + 32'd4;
          end
        end
      end
      UPDATE: begin
        state_next = FETCH;
        pc_next    = {tgt_word, 2'b00};
        redirect   = 1'b1;
      end
      FETCH: begin
        if (bus.imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls      <= 2'b00;
      br_type  <= 2'b00;
      off      <= 16'h0000;
      tgt_word <= 30'h0;
    end else if (state == IDLE && bus.instr_valid) begin
      cls      <= bus.br_class;
      br_type  <= bus.ShortBrType;
      off      <= bus.offset;
      tgt_word <= bus.target[31:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush     <= 1'b0;
      taken_cnt <= '0;
    end else begin
      flush <= redirect;
      if (redirect && taken_cnt != {CNT_W{1'b1}}) taken_cnt <= taken_cnt + 1'b1;
    end
  end

  // The call's return address is derived from pc, which still holds the old value in UPDATE.
  assign bus.instr_ready = (state == IDLE);
  assign bus.imem_req    = (state == FETCH);
  assign bus.pc          = pc;
  assign bus.flush       = flush;
  assign bus.link_we     = (state == UPDATE) && (cls == 2'b11);
  assign bus.link_data   = bus.link_we ? (pc + 32'd4) : 32'h0;
  assign bus.taken_cnt   = taken_cnt;

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16, width of the taken-branch counter.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 instr_valid  input  1  decoded control-flow info presented by decode.
REQ-006 instr_ready  output  1  sequencer can accept an instruction (high only in IDLE).
REQ-007 br_class  input  2  00 sequential, 01 short conditional, 10 long jump, 11 call.
REQ-008 ShortBrType  input  2  00 branch if positive (MSB=0), 01 if negative (MSB=1), 10 if zero, 11 if not zero.
REQ-009 offset  input  16  signed word offset for short branches.
REQ-010 target  input  32  absolute byte address for jump/call.
REQ-011 flag_valid  input  1  ALU flags valid this cycle.
REQ-012 zero  input  1  ALU result equals zero.
REQ-013 MSB  input  1  ALU result sign bit.
REQ-014 imem_req  output  1  fetch request at address pc.
REQ-015 imem_ack  input  1  fetch accepted by instruction memory.
REQ-016 pc  output  32  current program counter (registered).
REQ-017 flush  output  1  one-cycle pulse: squash wrong-path fetched instruction.
REQ-018 link_we  output  1  one-cycle pulse: write link register.
REQ-019 link_data  output  32  return address, valid while link_we=1.
REQ-020 taken_cnt  output  CNT_W  count of redirected control transfers.

Function
REQ-021 States SHALL be IDLE, WAIT_FLAG, UPDATE, FETCH; encoding free.
REQ-022 In IDLE, instr_valid=1 SHALL be a handshake: br_class, ShortBrType, offset, target latched that edge.
REQ-023 From IDLE: class 00 -> FETCH with pc <= pc+4; class 01 -> WAIT_FLAG; class 10/11 -> UPDATE.
REQ-024 WAIT_FLAG SHALL hold until flag_valid=1; flags sampled only in WAIT_FLAG, ignored in all other states.
REQ-025 On flag_valid in WAIT_FLAG: taken -> pc <= pc + 4 + (sext(offset) << 2); not taken -> pc <= pc+4; both -> FETCH.
REQ-026 Taken decision SHALL equal the ShortBrType table of REQ-008 applied to the sampled zero/MSB.
REQ-027 UPDATE SHALL last exactly one cycle: pc <= {target[31:2],2'b00}, then FETCH.
REQ-028 For class 11, link_we=1 and link_data=old pc+4 during the UPDATE cycle.
REQ-029 flush SHALL pulse one cycle on the edge a taken short branch, jump or call redirects pc; never for sequential or not-taken.
REQ-030 taken_cnt SHALL increment on each flush pulse and saturate at all-ones.
REQ-031 FETCH: imem_req=1 with pc stable; on imem_ack=1 -> IDLE next edge; imem_req=0 in all other states.
REQ-032 PC arithmetic SHALL be 32-bit modulo 2^32 (wraps, no error).
REQ-033 Accept-to-imem_req latency: class 00 = 1 cycle, class 10/11 = 2 cycles, class 01 = 2 cycles + flag wait.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, pc=RESET_PC, taken_cnt=0, imem_req=0, flush=0, link_we=0, link_data=0, independent of clk.
REQ-035 Reset mid-operation (any state) SHALL discard latched instruction; no flush or link_we pulse on release.
REQ-036 First edge after rst_n rises SHALL see instr_ready=1.

Verification
REQ-037 Reset, class 00 accepted, imem_ack after 3 cycles -> pc=4, imem_req held 3 cycles, back to IDLE, no flush.
REQ-038 pc=0x100, class 01, type 10, offset=-2, flag_valid after 2 cycles with zero=1 -> pc=0xFC, flush pulse, taken_cnt=1.
REQ-039 Same as 038 with zero=0 -> pc=0x104, no flush, taken_cnt unchanged.
REQ-040 pc=0x200, class 11, target=0x1003 -> link_we pulse with link_data=0x204, pc=0x1000, flush pulse.
REQ-041 pc=0xFFFF_FFFC, class 00 -> pc=0x0000_0000; taken_cnt preloaded near max by repeated jumps -> saturates.
REQ-042 rst_n dropped in WAIT_FLAG and in FETCH -> pc=RESET_PC and imem_req=0 before next clk edge.
